// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Tracks EX/MEM/WB destinations internally and counts load-use stall cycles.
module fwd_hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_valid,
  input  logic [4:0]             ex_dst,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   stall,
  output logic [4:0]             wb_dst,
  output logic                   wb_reg_write,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] mem_dst;
  logic       mem_rw;
  logic       mem_mr;
  logic       wb_rw;
  logic       unused_mem_mr;

  // MEM wins over WB; a destination of r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_dst,
                                         input logic       m_rw,
                                         input logic [4:0] w_dst,
                                         input logic       w_rw);
    if (m_rw && (m_dst != 5'd0) && (m_dst == src))
      return FWD_MEM;
    else if (w_rw && (w_dst != 5'd0) && (w_dst == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
    return (c == {STALL_CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign stall = id_valid && ex_mem_read && ex_reg_write && (ex_dst != 5'd0) &&
                 ((ex_dst == id_rs) || (ex_dst == id_rt));

  assign fwd_a        = fwd_sel(ex_rs, mem_dst, mem_rw, wb_dst, wb_rw);
  assign fwd_b        = fwd_sel(ex_rt, mem_dst, mem_rw, wb_dst, wb_rw);
  assign wb_reg_write = wb_rw;

  // The load flag travels with the MEM stage for the pipeline's benefit only.
  assign unused_mem_mr = mem_mr;

  // ID -> EX: a stall or an invalid ID slot becomes a bubble with no sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs <= 5'd0;
      ex_rt <= 5'd0;
    end else if (!stall && id_valid) begin
      ex_rs <= id_rs;
      ex_rt <= id_rt;
    end else begin
      ex_rs <= 5'd0;
      ex_rt <= 5'd0;
    end
  end

  // EX -> MEM -> WB destination tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dst <= 5'd0;
      mem_rw  <= 1'b0;
      mem_mr  <= 1'b0;
      wb_dst  <= 5'd0;
      wb_rw   <= 1'b0;
    end else begin
      mem_dst <= ex_dst;
      mem_rw  <= ex_reg_write;
      mem_mr  <= ex_mem_read;
      wb_dst  <= mem_dst;
      wb_rw   <= mem_rw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall)
      stall_count <= sat_inc(stall_count);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: table-driven pipeline trace plus
// reset-during-stall and counter saturation sequences.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_dst;
  logic       id_valid, ex_reg_write, ex_mem_read;

  logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic        stall, s_stall, wb_reg_write, s_wb_reg_write;
  logic [4:0]  wb_dst, s_wb_dst;
  logic [15:0] stall_count;
  logic [1:0]  s_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .wb_dst(wb_dst),
    .wb_reg_write(wb_reg_write), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .wb_dst(s_wb_dst),
    .wb_reg_write(s_wb_reg_write), .stall_count(s_stall_count)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       v;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [4:0] wd;
    logic       wr;
    int         cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic v,
                        input logic [4:0] dst, input logic rw, input logic mr);
    id_rs = rs; id_rt = rt; id_valid = v;
    ex_dst = dst; ex_reg_write = rw; ex_mem_read = mr;
  endtask

  initial begin
    //            rs     rt    v    dst   rw    mr    fa     fb     st    wd    wr   cnt
    tbl[0]  = '{5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 0};
    tbl[1]  = '{5'd2, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 5'd0, 1'b0, 0};
    tbl[2]  = '{5'd4, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd5, 1'b1, 0};
    tbl[3]  = '{5'd0, 5'd0, 1'b0, 5'd10,1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 5'd7, 1'b1, 0};
    tbl[4]  = '{5'd9, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 5'd8, 1'b1, 0};
    tbl[5]  = '{5'd9, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd10,1'b1, 1};
    tbl[6]  = '{5'd0, 5'd0, 1'b0, 5'd11,1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 5'd9, 1'b1, 1};
    tbl[7]  = '{5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 1};
    tbl[8]  = '{5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd11,1'b1, 1};
    tbl[9]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 5'd3, 1'b1, 1};
    tbl[10] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd3, 1'b1, 1};
    tbl[11] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b1, 1};
    tbl[12] = '{5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b1, 1};
    tbl[13] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 1};
    tbl[14] = '{5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd6, 1'b0, 1};
    tbl[15] = '{5'd0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 5'd0, 1'b0, 1};
    tbl[16] = '{5'd6, 5'd6, 1'b1, 5'd6, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd6, 1'b1, 2};
    tbl[17] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 5'd6, 1'b1, 2};

    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset fwd_a", fwd_a, 0);
    chk("reset fwd_b", fwd_b, 0);
    chk("reset stall", stall, 0);
    chk("reset wb_dst", wb_dst, 0);
    chk("reset wb_reg_write", wb_reg_write, 0);
    chk("reset stall_count", stall_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1 set_in(tbl[i].rs, tbl[i].rt, tbl[i].v, tbl[i].dst, tbl[i].rw, tbl[i].mr);
      @(negedge clk);
      chk($sformatf("row%0d fwd_a", i), fwd_a, tbl[i].fa);
      chk($sformatf("row%0d fwd_b", i), fwd_b, tbl[i].fb);
      chk($sformatf("row%0d stall", i), stall, tbl[i].st);
      chk($sformatf("row%0d wb_dst", i), wb_dst, tbl[i].wd);
      chk($sformatf("row%0d wb_reg_write", i), wb_reg_write, tbl[i].wr);
      chk($sformatf("row%0d stall_count", i), stall_count, tbl[i].cnt);
      chk($sformatf("row%0d sat fwd_a", i), s_fwd_a, tbl[i].fa);
      chk($sformatf("row%0d sat fwd_b", i), s_fwd_b, tbl[i].fb);
      chk($sformatf("row%0d sat stall", i), s_stall, tbl[i].st);
      chk($sformatf("row%0d sat wb_dst", i), s_wb_dst, tbl[i].wd);
      chk($sformatf("row%0d sat wb_reg_write", i), s_wb_reg_write, tbl[i].wr);
      chk($sformatf("row%0d sat stall_count", i), s_stall_count, tbl[i].cnt);
    end

    // Reset asserted while a load-use stall is pending
    @(posedge clk);
    #1 set_in(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    @(posedge clk);
    #1 set_in(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("pre-rst fwd_a", fwd_a, 2);
    chk("pre-rst fwd_b", fwd_b, 2);
    chk("pre-rst stall", stall, 1);
    chk("pre-rst stall_count", stall_count, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("in-rst fwd_a", fwd_a, 0);
    chk("in-rst fwd_b", fwd_b, 0);
    chk("in-rst wb_dst", wb_dst, 0);
    chk("in-rst wb_reg_write", wb_reg_write, 0);
    chk("in-rst stall_count", stall_count, 0);
    chk("in-rst sat stall_count", s_stall_count, 0);
    chk("in-rst stall follows inputs", stall, 1);
    set_in(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 set_in(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("post1 fwd_a", fwd_a, 0);
    chk("post1 fwd_b", fwd_b, 0);
    chk("post1 wb_reg_write", wb_reg_write, 0);
    @(posedge clk);
    #1 set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post2 fwd_a", fwd_a, 2);
    chk("post2 wb_reg_write", wb_reg_write, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post3 wb_dst", wb_dst, 5);
    chk("post3 wb_reg_write", wb_reg_write, 1);
    chk("post3 fwd_a", fwd_a, 0);
    chk("post3 stall_count", stall_count, 0);

    // Five load-use events, each followed by the EX bubble
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1 set_in(5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("sat%0d stall", k), stall, 1);
      @(posedge clk);
      #1 set_in(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("sat%0d bubble stall", k), stall, 0);
      chk($sformatf("sat%0d stall_count", k), stall_count, k);
      chk($sformatf("sat%0d sat stall_count", k), s_stall_count, (k > 3) ? 3 : k);
    end

    #1 rst_n = 1'b0;
    #1;
    chk("final rst stall_count", stall_count, 0);
    chk("final rst sat stall_count", s_stall_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
